// File: rtl/matmul_pkg.sv
// Shared types and defaults for the tiled matmul sequencer and its bench.
package matmul_pkg;

  localparam int unsigned DIM_W_DEF = 8;
  localparam int unsigned AW_DEF    = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seq_delay_pipe.sv
// Fixed-depth shift register with async active-low reset; DEPTH must be >= 1.
module seq_delay_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Address/strobe sequencer for the multi-MAC tiled matrix multiplier.
// Optional perf_cycles/perf_stalls counters are built when MATMUL_SEQ_PERF_EN is defined.
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned DIM_W      = DIM_W_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MAC_LAT    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIM_W-1:0]        cfg_k,
  input  logic [DIM_W-1:0]        cfg_rows,
  input  logic [DIM_W-1:0]        cfg_cols,
  input  logic                    stall,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    in_rd_en,
  output logic [AW-1:0]           in_addr,
  output logic [NUM_CORES-1:0]    wb_rd_en,
  output logic [NUM_CORES*AW-1:0] wb_addr,
  output logic [NUM_CORES-1:0]    mac_valid,
  output logic                    mac_first,
  output logic                    mac_last,
  output logic [NUM_CORES-1:0]    out_wr_en,
  output logic [NUM_CORES*AW-1:0] out_addr
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int unsigned WR_LAT = RD_LAT + MAC_LAT;

  seq_state_e       state_q, state_d;
  logic [DIM_W-1:0] k_dim_q, k_dim_d, r_dim_q, r_dim_d, c_dim_q, c_dim_d;
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
  // Running bases: in_base = r*K, wb_base = c*K, out_base = r*C.
  logic [AW-1:0]    in_base_q, in_base_d, wb_base_q, wb_base_d, out_base_q, out_base_d;
  logic [7:0]       drain_q, drain_d;
  logic             cfg_err_q, cfg_err_d, done_q, done_d;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0]      perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;
`endif

  logic                    issue, last_k, last_c, last_r, first_k;
  logic [NUM_CORES-1:0]    core_mask;
  logic [AW-1:0]           col_step, wb_off;
  logic [NUM_CORES*AW-1:0] out_addr_iss;
  logic [NUM_CORES+1:0]    mac_din, mac_dout;
  logic [NUM_CORES*(AW+1)-1:0] wr_din, wr_dout;

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    issue   = (state_q == ST_RUN) && !stall;
    first_k = (k_q == '0);
    last_k  = (k_q == k_dim_q - DIM_W'(1));
    last_r  = (r_q == r_dim_q - DIM_W'(1));
    last_c  = (32'(c_q) + NUM_CORES >= 32'(c_dim_q));
    col_step = '0;
    core_mask = '0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      col_step     = col_step + AW'(k_dim_q);
      core_mask[j] = (32'(c_q) + j < 32'(c_dim_q));
    end
    in_addr = in_base_q + AW'(k_q);
    wb_off  = wb_base_q + AW'(k_q);
    wb_addr = '0;
    out_addr_iss = '0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      wb_addr[j*AW +: AW]      = wb_off;
      wb_off                   = wb_off + AW'(k_dim_q);
      out_addr_iss[j*AW +: AW] = out_base_q + AW'(c_q) + AW'(j);
    end
  end

  assign in_rd_en = issue;
  assign wb_rd_en = issue ? core_mask : '0;

  always_comb begin
    state_d    = state_q;
    k_dim_d    = k_dim_q;
    r_dim_d    = r_dim_q;
    c_dim_d    = c_dim_q;
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    in_base_d  = in_base_q;
    wb_base_d  = wb_base_q;
    out_base_d = out_base_q;
    drain_d    = drain_q;
    cfg_err_d  = cfg_err_q;
    done_d     = (state_q == ST_DONE);
`ifdef MATMUL_SEQ_PERF_EN
    perf_cycles_d = busy ? perf_cycles_q + 32'd1 : perf_cycles_q;
    perf_stalls_d = ((state_q == ST_RUN) && stall) ? perf_stalls_q + 32'd1 : perf_stalls_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_dim_d   = cfg_k;
          r_dim_d   = cfg_rows;
          c_dim_d   = cfg_cols;
          cfg_err_d = 1'b0;
          state_d   = ST_LOAD;
`ifdef MATMUL_SEQ_PERF_EN
          perf_cycles_d = '0;
          perf_stalls_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        r_d        = '0;
        c_d        = '0;
        k_d        = '0;
        in_base_d  = '0;
        wb_base_d  = '0;
        out_base_d = '0;
        if (k_dim_q == '0 || r_dim_q == '0 || c_dim_q == '0) begin
          cfg_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (!last_k) begin
            k_d = k_q + DIM_W'(1);
          end else begin
            k_d = '0;
            if (!last_c) begin
              c_d       = c_q + DIM_W'(NUM_CORES);
              wb_base_d = wb_base_q + col_step;
            end else begin
              c_d       = '0;
              wb_base_d = '0;
              if (!last_r) begin
                r_d        = r_q + DIM_W'(1);
                in_base_d  = in_base_q + AW'(k_dim_q);
                out_base_d = out_base_q + AW'(c_dim_q);
              end else begin
                r_d        = '0;
                in_base_d  = '0;
                out_base_d = '0;
                drain_d    = 8'(WR_LAT - 1);
                state_d    = ST_DRAIN;
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_dim_q    <= '0;
      r_dim_q    <= '0;
      c_dim_q    <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      in_base_q  <= '0;
      wb_base_q  <= '0;
      out_base_q <= '0;
      drain_q    <= '0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef MATMUL_SEQ_PERF_EN
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_dim_q    <= k_dim_d;
      r_dim_q    <= r_dim_d;
      c_dim_q    <= c_dim_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      in_base_q  <= in_base_d;
      wb_base_q  <= wb_base_d;
      out_base_q <= out_base_d;
      drain_q    <= drain_d;
      cfg_err_q  <= cfg_err_d;
      done_q     <= done_d;
`ifdef MATMUL_SEQ_PERF_EN
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
`endif
    end
  end

  assign done    = done_q;
  assign cfg_err = cfg_err_q;
`ifdef MATMUL_SEQ_PERF_EN
  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

  // Strobe pipes keep shifting during stall so reads already issued still land.
  assign mac_din = {(issue ? core_mask : '0), issue && first_k, issue && last_k};
  assign wr_din  = {((issue && last_k) ? core_mask : '0), out_addr_iss};

  seq_delay_pipe #(.DEPTH(RD_LAT), .WIDTH(NUM_CORES + 2)) u_mac_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (mac_din),
    .dout (mac_dout)
  );

  seq_delay_pipe #(.DEPTH(WR_LAT), .WIDTH(NUM_CORES * (AW + 1))) u_wr_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (wr_din),
    .dout (wr_dout)
  );

  assign {mac_valid, mac_first, mac_last} = mac_dout;
  assign {out_wr_en, out_addr}            = wr_dout;

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (!rst_n)
    (BLOCK_SIZE > 0) && !(ready && busy));

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Randomized/directed bench for matmul_tile_sequencer against a loop-nest reference model.
module tb_matmul_tile_sequencer;
  import matmul_pkg::*;

  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int AW  = 14;
  localparam int RD  = 2;
  localparam int ML  = 3;
  localparam int WRL = RD + ML;

  logic clk = 1'b0;
  logic rst_n, start, stall;
  logic [DW-1:0] cfg_k, cfg_rows, cfg_cols;
  logic ready, busy, done, cfg_err, in_rd_en, mac_first, mac_last;
  logic [AW-1:0] in_addr;
  logic [NC-1:0] wb_rd_en, mac_valid, out_wr_en;
  logic [NC*AW-1:0] wb_addr, out_addr;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  matmul_tile_sequencer #(
    .BLOCK_SIZE(2), .NUM_CORES(NC), .DIM_W(DW), .AW(AW), .RD_LAT(RD), .MAC_LAT(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols), .stall(stall), .ready(ready), .busy(busy), .done(done),
    .cfg_err(cfg_err), .in_rd_en(in_rd_en), .in_addr(in_addr), .wb_rd_en(wb_rd_en),
    .wb_addr(wb_addr), .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
    .out_wr_en(out_wr_en), .out_addr(out_addr)
`ifdef MATMUL_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0]    ia;
    logic [NC*AW-1:0] wa;
    logic [NC-1:0]    m;
    logic             f;
    logic             l;
    logic [NC*AW-1:0] oa;
  } iss_t;
  typedef struct packed { logic [NC-1:0] mv; logic mf; logic ml; } macx_t;
  typedef struct packed { logic [NC-1:0] we; logic [NC*AW-1:0] oa; } wrx_t;

  macx_t e_mac [int];
  wrx_t  e_wr  [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rd_en", in_rd_en, 0);
      chk("idle_mac_valid", mac_valid, 0);
      chk("idle_wr_en", out_wr_en, 0);
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 0 no stall, 1 stall on RUN cycles 5..9, 2 random stall
  task automatic run_job(input int kk, input int rr, input int cc, input int mode,
                         input bit storm, input int abort_at);
    iss_t  q[$];
    iss_t  it;
    macx_t mx;
    wrx_t  wx;
    int s, c, col, end_busy, done_c, remaining, nstall, pulses;
    bit err, exp_iss, exp_busy, exp_ready;
    for (int r = 0; r < rr; r++)
      for (int cb = 0; cb < int'(ceil_div(cc, NC)); cb++)
        for (int k = 0; k < kk; k++) begin
          it = '0;
          it.ia = AW'(r * kk + k);
          it.f  = (k == 0);
          it.l  = (k == kk - 1);
          for (int j = 0; j < NC; j++) begin
            col = cb * NC + j;
            it.m[j] = (col < cc);
            it.wa[j*AW +: AW] = AW'(col * kk + k);
            it.oa[j*AW +: AW] = AW'(r * cc + col);
          end
          q.push_back(it);
        end
    err       = (kk == 0 || rr == 0 || cc == 0);
    remaining = q.size();
    s         = cyc;
    end_busy  = err ? s + 1 : -1;
    done_c    = err ? s + 3 : -1;
    nstall    = 0;
    pulses    = 0;
    forever begin
      c = cyc;
      if (c == s) begin
        start = 1'b1; cfg_k = DW'(kk); cfg_rows = DW'(rr); cfg_cols = DW'(cc);
      end else begin
        start = (storm && (done_c < 0 || c < done_c)) ? 1'($urandom_range(0, 1)) : 1'b0;
        cfg_k = DW'($urandom); cfg_rows = DW'($urandom); cfg_cols = DW'($urandom);
      end
      case (mode)
        1:       stall = (c >= s + 7 && c <= s + 11);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      if (abort_at > 0 && c == s + abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_wb_rd_en", wb_rd_en, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_mac_last", mac_last, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_out_addr", out_addr, 0);
        start = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_mac.delete();
        e_wr.delete();
        return;
      end
      @(negedge clk);
      exp_iss = !err && c >= s + 2 && remaining > 0 && !stall;
      if (!err && c >= s + 2 && remaining > 0 && stall) nstall++;
      chk("in_rd_en", in_rd_en, exp_iss);
      if (exp_iss) begin
        it = q.pop_front();
        chk("in_addr", in_addr, it.ia);
        chk("wb_rd_en", wb_rd_en, it.m);
        for (int j = 0; j < NC; j++)
          if (it.m[j]) chk("wb_addr", wb_addr[j*AW +: AW], it.wa[j*AW +: AW]);
        e_mac[c + RD] = '{mv: it.m, mf: it.f, ml: it.l};
        if (it.l) e_wr[c + WRL] = '{we: it.m, oa: it.oa};
        remaining--;
        if (remaining == 0) begin
          end_busy = c + WRL;
          done_c   = c + WRL + 2;
        end
      end else begin
        chk("wb_rd_en_idle", wb_rd_en, 0);
      end
      mx = e_mac.exists(c) ? e_mac[c] : '0;
      wx = e_wr.exists(c) ? e_wr[c] : '0;
      chk("mac_valid", mac_valid, mx.mv);
      chk("mac_first", mac_first, mx.mf);
      chk("mac_last", mac_last, mx.ml);
      chk("out_wr_en", out_wr_en, wx.we);
      for (int j = 0; j < NC; j++)
        if (wx.we[j]) chk("out_addr", out_addr[j*AW +: AW], wx.oa[j*AW +: AW]);
      exp_busy  = c > s && (end_busy < 0 || c <= end_busy);
      exp_ready = !(c > s && (end_busy < 0 || c <= end_busy + 1));
      chk("busy", busy, exp_busy);
      chk("ready", ready, exp_ready);
      chk("done", done, (c == done_c));
      if (c == s + 1) chk("cfg_err_clr", cfg_err, 0);
      if (c >= s + 2) chk("cfg_err", cfg_err, err);
      if (done === 1'b1) pulses++;
`ifdef MATMUL_SEQ_PERF_EN
      if (c == done_c) begin
        chk("perf_cycles", perf_cycles, end_busy - s);
        chk("perf_stalls", perf_stalls, nstall);
      end
`endif
      @(posedge clk);
      #1;
      if (done_c >= 0 && c >= done_c + 1) break;
      if (c > s + 4000) begin
        chk("job_timeout", 0, 1);
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    chk("done_pulses", pulses, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    cfg_k = '0; cfg_rows = '0; cfg_cols = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_rd_en", in_rd_en, 0);
    chk("reset_wb_rd_en", wb_rd_en, 0);
    chk("reset_in_addr", in_addr, 0);
    chk("reset_mac_valid", mac_valid, 0);
    chk("reset_wr_en", out_wr_en, 0);
    chk("reset_out_addr", out_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    run_job(4, 8, 8, 0, 1'b0, 0);  idle(2);
    run_job(2, 1, 3, 0, 1'b0, 0);  idle(2);
    run_job(3, 0, 2, 0, 1'b0, 0);  idle(2);
    run_job(1, 1, 1, 0, 1'b0, 0);  idle(2);
    run_job(0, 2, 2, 2, 1'b0, 0);  idle(1);
    run_job(2, 2, 0, 0, 1'b0, 0);  idle(1);
    run_job(4, 2, 2, 1, 1'b0, 0);  idle(2);
    run_job(3, 2, 5, 2, 1'b1, 0);  idle(2);
    run_job(4, 3, 4, 0, 1'b0, 20); idle(12);
    run_job(4, 3, 4, 0, 1'b0, 0);  idle(2);
    for (int i = 0; i < 6; i++) begin
      run_job(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 5)), 2, 1'($urandom_range(0, 1)), 0);
      idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
- Address and control sequencer for the multi-MAC tiled matrix multiplier.
- Walks output blocks C[r][c] in row-major order and, for each one, steps through the inner dimension k.
- Drives the read addresses for the input BRAM and the weight BRAMs, the accumulate-first/last strobes for NUM_CORES parallel MAC cores, and the output-BRAM write strobe.
- Matrix dimensions are runtime-programmable in block units and are latched on start, replacing the fixed-size MAX_FLAG controller.

Parameters:
- BLOCK_SIZE, 2, systolic tile dimension (N x N); informational only, used in address comments and assertions.
- NUM_CORES, 2, parallel MAC cores; each core computes one column block.
- DIM_W, 8, width of each runtime dimension field, in blocks.
- AW, 14, BRAM address width, shared by input, weight and output.
- RD_LAT, 2, BRAM read latency in cycles.
- MAC_LAT, 3, cycles from the last MAC operand to a valid accumulated result.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- cfg_k  in  DIM_W  inner dimension in blocks (K)
- cfg_rows  in  DIM_W  output row blocks (R)
- cfg_cols  in  DIM_W  output column blocks (C)
- stall  in  1  freezes issue while high
- ready  out  1  high in IDLE
- busy  out  1  high in LOAD, RUN and DRAIN
- done  out  1  one-cycle pulse at completion
- cfg_err  out  1  sticky until next start; set when any dimension is 0
- in_rd_en  out  1  input BRAM read enable
- in_addr  out  AW  input block address, r*K + k
- wb_rd_en  out  NUM_CORES  per-core weight read enable; equals core_mask
- wb_addr  out  NUM_CORES*AW  core j address, (c+j)*K + k
- mac_valid  out  NUM_CORES  operands valid at the MACs
- mac_first  out  1  k == 0 at the MACs; clear the accumulator
- mac_last  out  1  k == K-1 at the MACs
- out_wr_en  out  NUM_CORES  per-core result write enable
- out_addr  out  NUM_CORES*AW  core j address, r*C + c + j

Behaviour:
- Reset: all outputs 0 except ready=1; FSM goes to IDLE; all counters and delay pipes are cleared. Asserting reset mid-operation aborts with no done pulse.
- FSM states: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 latches cfg_k, cfg_rows and cfg_cols, clears cfg_err, and moves to LOAD. start in any other state is ignored.
  - LOAD (1 cycle): if any dimension is 0, set cfg_err and go to DONE with no reads issued. Otherwise set r=c=k=0 and go to RUN.
  - RUN: one issue per cycle while stall=0; stall=1 holds r, c, k and deasserts the read enables.
  - Counter order: k increments first; at k=K-1, k wraps and c += NUM_CORES; at c+NUM_CORES >= C, c wraps and r++.
  - After the issue at r=R-1, last c, k=K-1, go to DRAIN.
  - DRAIN: wait RD_LAT+MAC_LAT cycles so that the last out_wr_en has occurred, then go to DONE.
  - DONE (1 cycle): done=1, then IDLE.
- Column tail: core_mask[j] = (c+j < C). Masked cores get wb_rd_en, mac_valid and out_wr_en all 0; their addresses are don't-care.
- Latency:
  - First in_rd_en occurs 2 cycles after start is sampled.
  - mac_valid, mac_first and mac_last are the issue strobes delayed by RD_LAT through a shift pipe. The pipe runs regardless of stall, so in-flight reads complete.
  - out_wr_en is the mac_last issue strobe, gated by core_mask, delayed by RD_LAT+MAC_LAT. out_addr is delayed alongside it.
- Issue count without stall: R * ceil(C/NUM_CORES) * K. Total writes: R*C.
- Arithmetic: addresses are computed with incremental adders (base += K per row/column step), not multipliers, and truncate to AW bits. Products that exceed 2^AW are a software error and are not detected.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- When defined: extra outputs perf_cycles[31:0] and perf_stalls[31:0].
  - Both clear on accepted start.
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts RUN cycles with stall=1.
  - Both hold their values after done.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package matmul_pkg:
  - fsm state enum (IDLE, LOAD, RUN, DRAIN, DONE)
  - DIM_W and AW defaults
  - function ceil_div used by the bench
- One sub-module, seq_delay_pipe: parametrised depth and width shift register with async reset. Instantiated for the RD_LAT strobes and for the RD_LAT+MAC_LAT write strobe and address.

Test Plan:
- K=4, R=8, C=8, NUM_CORES=1, no stall -> 256 issues; first in_addr=0/wb_addr=0, fifth in_addr=0/wb_addr=4; 64 writes with out_addr 0..63 in order; done exactly once; ready back high.
- K=2, R=1, C=3, NUM_CORES=2 -> issues at c=0 (mask 11) and c=2 (mask 01); out_wr_en 11 then 01; out_addr {0,1} then {2,x}.
- cfg_rows=0 -> cfg_err=1, no in_rd_en, done 3 cycles after start; next valid start clears cfg_err.
- K=4, R=2, C=2, stall high for cycles 5-9 of RUN -> address sequence unchanged; done delayed 5 cycles; perf_stalls=5 with MATMUL_SEQ_PERF_EN.
- Assert start repeatedly during RUN -> ignored, single done. rst_n low mid-RUN -> outputs 0 and ready=1 immediately, no done; a fresh start completes normally.
- RD_LAT=1, MAC_LAT=1 build -> out_wr_en exactly 2 cycles after the corresponding mac_last issue strobe.
